// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional signed-overflow output enabled by defining CLA_OVF_EN.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             g_star,
    output logic             p_star
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NG  = WIDTH / 4;
    localparam int unsigned NSG = (NG + 3) / 4;

    // Stage 1: effective operands, bit terms and 4-bit group lookahead
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [NG-1:0]    grp_g_d;
    logic [NG-1:0]    grp_p_d;

    assign b_eff = b ^ {WIDTH{sub}};
    assign c_eff = sub | cin;
    assign g_bit = a & b_eff;
    assign p_bit = a ^ b_eff;

    always_comb begin
        grp_g_d = '0;
        grp_p_d = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            grp_g_d[k] = g_bit[4*k+3]
                       | (p_bit[4*k+3] & g_bit[4*k+2])
                       | (p_bit[4*k+3] & p_bit[4*k+2] & g_bit[4*k+1])
                       | (p_bit[4*k+3] & p_bit[4*k+2] & p_bit[4*k+1] & g_bit[4*k]);
            grp_p_d[k] = &p_bit[4*k +: 4];
        end
    end

    logic             v1_q;
    logic             v2_q;
    logic [WIDTH-1:0] p1_q;
    logic [WIDTH-1:0] g1_q;
    logic [NG-1:0]    gg1_q;
    logic [NG-1:0]    gp1_q;
    logic             c1_q;

    // Stage 2: supergroup, group and in-group lookahead
    logic [NSG-1:0] sg_g;
    logic [NSG-1:0] sg_p;
    logic [NSG:0]   sg_c;
    logic [NG-1:0]  grp_c;
    logic [WIDTH:0] c;
    logic           top_g;
    logic           top_p;

    always_comb begin
        sg_g  = '0;
        sg_p  = '0;
        sg_c  = '0;
        grp_c = '0;
        c     = '0;
        top_g = 1'b0;
        top_p = 1'b1;
        for (int unsigned s = 0; s < NSG; s++) begin
            sg_p[s] = 1'b1;
            for (int unsigned j = 0; j < 4; j++) begin
                // Last supergroup may hold fewer than 4 groups
                if (4*s + j < NG) begin
                    sg_g[s] = gg1_q[4*s+j] | (gp1_q[4*s+j] & sg_g[s]);
                    sg_p[s] = sg_p[s] & gp1_q[4*s+j];
                end
            end
        end
        sg_c[0] = c1_q;
        for (int unsigned s = 0; s < NSG; s++) begin
            sg_c[s+1] = sg_g[s] | (sg_p[s] & sg_c[s]);
            top_g     = sg_g[s] | (sg_p[s] & top_g);
            top_p     = top_p & sg_p[s];
        end
        for (int unsigned k = 0; k < NG; k++) begin
            if (k % 4 == 0) begin
                grp_c[k] = sg_c[k/4];
            end else begin
                grp_c[k] = gg1_q[k-1] | (gp1_q[k-1] & grp_c[k-1]);
            end
        end
        for (int unsigned k = 0; k < NG; k++) begin
            c[4*k] = grp_c[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g1_q[4*k+j] | (p1_q[4*k+j] & c[4*k+j]);
            end
        end
        c[WIDTH] = sg_c[NSG];
    end

    // Handshake: only out_ready reaches in_ready combinationally
    logic s2_load;
    logic s1_load;
    logic accept;

    assign s2_load  = !v2_q || out_ready;
    assign s1_load  = !v1_q || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             gs_q;
    logic             ps_q;
`ifdef CLA_OVF_EN
    logic             ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p1_q   <= '0;
            g1_q   <= '0;
            gg1_q  <= '0;
            gp1_q  <= '0;
            c1_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            gs_q   <= 1'b0;
            ps_q   <= 1'b0;
`ifdef CLA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            if (s1_load) begin
                v1_q <= in_valid;
            end
            if (accept) begin
                p1_q  <= p_bit;
                g1_q  <= g_bit;
                gg1_q <= grp_g_d;
                gp1_q <= grp_p_d;
                c1_q  <= c_eff;
            end
            if (s2_load) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sum_q  <= p1_q ^ c[WIDTH-1:0];
                    cout_q <= c[WIDTH];
                    gs_q   <= top_g;
                    ps_q   <= top_p;
`ifdef CLA_OVF_EN
                    ovf_q  <= c[WIDTH] ^ c[WIDTH-1];
`endif
                end
            end
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign g_star    = gs_q;
    assign p_star    = ps_q;
`ifdef CLA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: arithmetic reference model, random and directed stimulus.
// Define CLA_OVF_EN to also check the ovf output.
module tb_pipelined_cla_adder;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         g_star;
    logic         p_star;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .g_star    (g_star),
        .p_star    (p_star)
`ifdef CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         g;
        logic         p;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_done;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t         e;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        logic [W:0]   nocarry;
        be      = sv ? ~bv : bv;
        ce      = sv ? 1'b1 : cv;
        full    = {1'b0, av} + {1'b0, be} + (W+1)'(ce);
        nocarry = {1'b0, av} + {1'b0, be};
        e.sum   = full[W-1:0];
        e.cout  = full[W];
        e.g     = nocarry[W];
        e.p     = ((av ^ be) == {W{1'b1}});
        e.ovf   = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
        return e;
    endfunction

    // Drive one operand set; push expected at the accepting edge
    task automatic send_e(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv, input exp_t e);
        bit rdy;
        bit done = 0;
        int n = 0;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1;
                q.push_back(e);
            end else if (++n > 50) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: in_ready stuck at 0, want 1");
                done = 1;
            end
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv);
        send_e(av, bv, cv, sv, model(av, bv, cv, sv));
    endtask

    task automatic send_x(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic sv, input logic [W-1:0] s, input logic co,
                          input logic g, input logic p, input logic o);
        exp_t e;
        e.sum = s; e.cout = co; e.g = g; e.p = p; e.ovf = o;
        send_e(av, bv, cv, sv, e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Monitor: every presented result (stalled or not) must equal the queue head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_output: got sum %h, want no output", sum);
            end else begin
`ifdef CLA_OVF_EN
                check("result", 64'({sum, cout, g_star, p_star, ovf}),
                      64'({q[0].sum, q[0].cout, q[0].g, q[0].p, q[0].ovf}));
`else
                check("result", 64'({sum, cout, g_star, p_star}),
                      64'({q[0].sum, q[0].cout, q[0].g, q[0].p}));
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", 64'({cout, g_star, p_star}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef CLA_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk); #1;

        // Basic add, with bounded wait for the result to appear
        send_x(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 3);
        check("latency_valid_seen", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Back-to-back: propagate-only word, then carry rippling all the way
        send_x(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send_x(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        send_x(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        send_x(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
        send_x(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        send_x(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        send_x(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: 4 sets while the consumer stalls
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_full", 64'(in_ready), 64'd0);
                @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_held", 64'(in_ready), 64'd0);
                check("bp_queue_depth", 64'(q.size()), 64'd2);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random consumer stalls
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b1, 1'b1);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum_cout", 64'({sum, cout}), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        send(16'h0000, 16'h0001, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
